// File: rtl/dram_stream_reader_if.sv
// rtl/dram_stream_reader_if.sv - AXI read address/data channel bundle for the DRAM stream reader
// AR: araddr, arvalid, arready, arlen, arsize, arburst
// R : rdata, rvalid, rready, rlast, rresp
// master = reader (issues AR, accepts R); slave = memory side
interface dram_stream_reader_if #(
  parameter int DATA_W = 64
);
  logic [31:0]       araddr;
  logic              arvalid;
  logic              arready;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rready;
  logic              rlast;
  logic [1:0]        rresp;

  modport master (
    output araddr, arvalid, arlen, arsize, arburst, rready,
    input  arready, rdata, rvalid, rlast, rresp
  );

  modport slave (
    input  araddr, arvalid, arlen, arsize, arburst, rready,
    output arready, rdata, rvalid, rlast, rresp
  );
endinterface

// File: rtl/dram_stream_reader.sv
// rtl/dram_stream_reader.sv - frame reader: AXI INCR bursts from DRAM into a FWFT output stream
// fclk, rst_n                : clock, async active-low reset
// cfg_valid/ready, cfg_addr, cfg_bytes, cfg_loop : frame command
// stop                       : end loop mode at the next frame boundary
// axi (master)               : AXI read address and read data channels
// dout, dout_valid/ready     : output stream
// frame_done, busy, err, level : status
module dram_stream_reader #(
  parameter int DATA_W          = 64,
  parameter int BURST_LEN       = 16,
  parameter int FIFO_DEPTH      = 512,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                        fclk,
  input  logic                        rst_n,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [31:0]                 cfg_addr,
  input  logic [31:0]                 cfg_bytes,
  input  logic                        cfg_loop,
  input  logic                        stop,
  dram_stream_reader_if.master        axi,
  output logic [DATA_W-1:0]           dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic                        frame_done,
  output logic                        busy,
  output logic                        err,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int BB = BURST_LEN * DATA_W / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t state, state_n;

  logic [31:0] base_q, bytes_q, off_q;
  logic        loop_q, stop_q;
  logic [OW-1:0] outst, outst_n, push_pos;
  // One mark per in-flight burst, oldest in bit 0: set when the burst closes
  // a frame that loops back, so its rlast produces the frame_done pulse.
  logic [MAX_OUTSTANDING-1:0] loop_mark, mark_n;
  logic [7:0]  beat_cnt;
  logic        arvalid_q;
  logic [31:0] araddr_q;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;

  logic        cfg_hs, cfg_ok, ar_hs, r_hs, r_last_hs;
  logic        last_burst, keep_looping, credit_ok, issue;
  logic        fifo_full, fifo_empty, wr_en, pop, frame_done_n;
  logic [31:0] free_words, need_words;

  assign cfg_ready    = (state == IDLE) && rst_n;
  assign busy         = (state != IDLE);
  assign cfg_hs       = cfg_valid && cfg_ready;
  assign cfg_ok       = (cfg_bytes != 32'd0) && ((cfg_bytes % 32'(BB)) == 32'd0);
  assign ar_hs        = arvalid_q && axi.arready;
  assign r_hs         = axi.rvalid && axi.rready;
  assign r_last_hs    = r_hs && axi.rlast;
  assign last_burst   = (off_q + 32'(BB)) == bytes_q;
  assign keep_looping = loop_q && !(stop_q || stop);

  // Each outstanding burst reserves a full burst of FIFO space, so data can
  // never be stalled by a full buffer.
  assign free_words = 32'(FIFO_DEPTH) - 32'(count);
  assign need_words = (32'(outst) + 32'd1) * 32'(BURST_LEN);
  assign credit_ok  = (32'(outst) < 32'(MAX_OUTSTANDING)) && (need_words <= free_words);
  assign issue      = (state == ISSUE) && !arvalid_q && credit_ok;

  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign pop        = dout_valid && dout_ready;
  assign wr_en      = r_hs && (!fifo_full || pop);

  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = 8'(BURST_LEN - 1);
  assign axi.arsize  = 3'($clog2(DATA_W / 8));
  assign axi.arburst = 2'b01;
  assign axi.rready  = (outst != '0) && !fifo_full;

  assign dout       = mem[rd_ptr];
  assign dout_valid = !fifo_empty;
  assign level      = count;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cfg_hs && cfg_ok) state_n = ISSUE;
      ISSUE:   if (ar_hs && last_burst && !keep_looping) state_n = DRAIN;
      DRAIN:   if (outst == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    outst_n = outst;
    if (ar_hs)     outst_n = outst_n + OW'(1);
    if (r_last_hs) outst_n = outst_n - OW'(1);
  end

  always_comb begin
    mark_n   = loop_mark;
    push_pos = outst;
    if (r_last_hs) begin
      mark_n   = loop_mark >> 1;
      push_pos = outst - OW'(1);
    end
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (ar_hs && (push_pos == OW'(i))) mark_n[i] = last_burst && keep_looping;
    end
  end

  // Final frame completes through DRAIN; looping frames complete on the
  // rlast of their marked last burst. The two cannot coincide.
  assign frame_done_n = ((state == DRAIN) && (outst == '0)) || (r_last_hs && loop_mark[0]);

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      bytes_q    <= '0;
      off_q      <= '0;
      loop_q     <= 1'b0;
      stop_q     <= 1'b0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      outst      <= '0;
      loop_mark  <= '0;
      beat_cnt   <= '0;
      err        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      outst      <= outst_n;
      loop_mark  <= mark_n;
      frame_done <= frame_done_n;

      if (state == IDLE) begin
        stop_q <= 1'b0;
      end else if (stop) begin
        stop_q <= 1'b1;
      end

      if (state == IDLE) begin
        if (cfg_hs) begin
          base_q  <= cfg_addr;
          bytes_q <= cfg_bytes;
          loop_q  <= cfg_loop;
          off_q   <= '0;
          if (!cfg_ok) err <= 1'b1;
        end
      end else if (issue) begin
        arvalid_q <= 1'b1;
        araddr_q  <= base_q + off_q;
      end else if (ar_hs) begin
        arvalid_q <= 1'b0;
        off_q     <= last_burst ? 32'd0 : off_q + 32'(BB);
      end

      if (r_hs) begin
        if (axi.rlast) begin
          beat_cnt <= '0;
          if (beat_cnt != 8'(BURST_LEN - 1)) err <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 8'd1;
          if (beat_cnt == 8'(BURST_LEN - 1)) err <= 1'b1;
        end
        if (axi.rresp != 2'b00) err <= 1'b1;
      end
      if (axi.rvalid && (outst == '0)) err <= 1'b1;
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count <= count + (wr_en ? (AW+1)'(1) : '0) - (pop ? (AW+1)'(1) : '0);
    end
  end

  always_ff @(posedge fclk) begin
    if (wr_en) mem[wr_ptr] <= axi.rdata;
  end

endmodule

// File: tb/tb_dram_stream_reader.sv
// tb/tb_dram_stream_reader.sv - directed self-checking bench for dram_stream_reader
module tb_dram_stream_reader;

  logic        fclk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_loop, stop, dout_ready;
  logic        cfg_ready, dout_valid, frame_done, busy, err;
  logic [31:0] cfg_addr, cfg_bytes;
  logic [63:0] dout;
  logic [9:0]  level;

  always #5 fclk = ~fclk;

  dram_stream_reader_if #(.DATA_W(64)) axi ();

  dram_stream_reader #(
    .DATA_W(64), .BURST_LEN(16), .FIFO_DEPTH(512), .MAX_OUTSTANDING(2)
  ) dut (
    .fclk(fclk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_bytes(cfg_bytes), .cfg_loop(cfg_loop), .stop(stop),
    .axi(axi),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .frame_done(frame_done), .busy(busy), .err(err), .level(level)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // memory model and monitor state
  logic [31:0] bq_addr[$];
  int          bq_len[$];
  logic [31:0] ar_log[$];
  int          beat_i = 0, glob_beat = 0, inj_resp_at = -1, r_blocked = 0;
  bit          ar_stall = 0, inj_early = 0, stray = 0;
  bit          pred_ar = 0, pred_r = 0;
  logic [31:0] pred_addr = '0;
  logic [31:0] exp_base = '0;
  int          frame_words = 0, word_idx = 0, skip_at = 1 << 30, fd_count = 0;
  int          lvl_max = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge fclk);
    #1;
  endtask

  // Responder: at negedge+2 apply handshakes predicted for the last posedge,
  // drive this cycle's AR/R inputs, then predict the coming handshakes.
  initial begin
    logic [31:0] a;
    bit s;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rlast = 1'b0; axi.rresp = 2'b00;
    forever begin
      @(negedge fclk);
      #2;
      s = 0;
      if (!rst_n) begin
        bq_addr.delete(); bq_len.delete(); beat_i = 0; pred_ar = 0; pred_r = 0;
      end
      if (pred_ar) begin
        bq_addr.push_back(pred_addr);
        bq_len.push_back(inj_early ? 15 : 16);
        inj_early = 0;
        ar_log.push_back(pred_addr);
      end
      if (pred_r) begin
        beat_i++; glob_beat++;
        if (beat_i == bq_len[0]) begin
          void'(bq_addr.pop_front()); void'(bq_len.pop_front()); beat_i = 0;
        end
      end
      axi.arready = rst_n && !ar_stall;
      if (bq_addr.size() != 0) begin
        a = bq_addr[0] + 32'(beat_i * 8);
        axi.rvalid = 1'b1; axi.rdata = {~a, a};
        axi.rlast  = (beat_i == bq_len[0] - 1);
        axi.rresp  = (glob_beat == inj_resp_at) ? 2'd2 : 2'd0;
      end else if (stray) begin
        axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.rdata = '0; axi.rresp = 2'b00;
        stray = 0; s = 1;
      end else begin
        axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
      end
      #1;
      pred_ar   = axi.arvalid && axi.arready;
      pred_addr = axi.araddr;
      pred_r    = axi.rvalid && axi.rready;
      if (rst_n && axi.rvalid && !axi.rready && !s) r_blocked++;
    end
  end

  // Stream monitor: checks every word popped at the coming posedge.
  initial begin
    logic [31:0] a;
    int idx;
    forever begin
      @(negedge fclk);
      #4;
      if (rst_n && dout_valid && dout_ready) begin
        idx = word_idx + ((word_idx >= skip_at) ? 1 : 0);
        if (frame_words != 0) idx = idx % frame_words;
        a = exp_base + 32'(idx * 8);
        chk("dout", dout, {~a, a});
        word_idx++;
      end
      if (frame_done) fd_count++;
      if (int'(level) > lvl_max) lvl_max = int'(level);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic start_frame(input logic [31:0] addr, input logic [31:0] bytes, input logic lp);
    fd_count = 0; word_idx = 0; lvl_max = 0; r_blocked = 0;
    ar_log.delete();
    exp_base    = addr;
    frame_words = lp ? int'(bytes / 8) : 0;
    cfg_addr = addr; cfg_bytes = bytes; cfg_loop = lp; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!(busy === 1'b0 && level === '0 && dout_valid === 1'b0) && n < budget) begin
      step(); n++;
    end
    chk(tag, 64'(n < budget), 64'd1);
    repeat (3) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int n;
    bit dv_before;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_loop = 1'b0; stop = 1'b0; dout_ready = 1'b1;
    cfg_addr = '0; cfg_bytes = '0;
    step();
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_rready", axi.rready, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_level", level, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_araddr", axi.araddr, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("cfg_ready_after_rst", cfg_ready, 1);

    // single frame, 4 bursts
    start_frame(32'h1000, 32'd512, 1'b0);
    n = 0; dv_before = 1;
    while (!pred_r && n < 50) begin dv_before = dout_valid; step(); n++; end
    chk("first_beat_seen", 64'(n < 50), 1);
    chk("dv_before_beat", dv_before, 0);
    chk("dv_after_beat", dout_valid, 1);
    wait_idle("s1_idle", 1000);
    chk("s1_ar_count", ar_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("s1_araddr", ar_log[i], 32'h1000 + 32'(i * 32'h80));
    chk("s1_words", word_idx, 64);
    chk("s1_frame_done", fd_count, 1);
    chk("s1_busy", busy, 0);
    chk("s1_err", err, 0);

    // back-pressure: reservation fills the 512-word buffer
    dout_ready = 1'b0;
    start_frame(32'h2000, 32'd8192, 1'b0);
    n = 0;
    while (level != 10'd512 && n < 3000) begin step(); n++; end
    chk("s2_level_peak", level, 512);
    repeat (40) step();
    chk("s2_ar_held", ar_log.size(), 32);
    chk("s2_level_hold", level, 512);
    chk("s2_rready_full", axi.rready, 0);
    dout_ready = 1'b1;
    wait_idle("s2_idle", 6000);
    chk("s2_words", word_idx, 1024);
    chk("s2_ar_count", ar_log.size(), 64);
    chk("s2_level_max", lvl_max, 512);
    chk("s2_r_blocked", r_blocked, 0);
    chk("s2_frame_done", fd_count, 1);

    // loop mode with stop in the third frame
    start_frame(32'h1000, 32'd256, 1'b1);
    n = 0;
    while (ar_log.size() < 5 && n < 500) begin step(); n++; end
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_idle("s3_idle", 2000);
    chk("s3_frame_done", fd_count, 3);
    chk("s3_ar_count", ar_log.size(), 6);
    for (int i = 0; i < 6; i++) chk("s3_araddr", ar_log[i], (i % 2 == 0) ? 32'h1000 : 32'h1080);
    chk("s3_words", word_idx, 96);
    chk("s3_busy", busy, 0);

    // address wrap past 0xFFFFFFFF
    start_frame(32'hFFFF_FF80, 32'd256, 1'b0);
    wait_idle("s4_idle", 1000);
    chk("s4_ar0", ar_log[0], 32'hFFFF_FF80);
    chk("s4_ar1", ar_log[1], 32'h0000_0000);
    chk("s4_err", err, 0);
    chk("s4_words", word_idx, 32);

    // arready stall: address channel must hold
    ar_stall = 1;
    start_frame(32'h3000, 32'd128, 1'b0);
    n = 0;
    while (axi.arvalid !== 1'b1 && n < 20) begin step(); n++; end
    for (int i = 0; i < 10; i++) begin
      chk("s5_arvalid_hold", axi.arvalid, 1);
      chk("s5_araddr_hold", axi.araddr, 32'h3000);
      step();
    end
    ar_stall = 0;
    wait_idle("s5_idle", 1000);
    chk("s5_ar_count", ar_log.size(), 1);
    chk("s5_words", word_idx, 16);

    // error response on one beat; data still forwarded, err sticky
    inj_resp_at = glob_beat + 5;
    start_frame(32'h4000, 32'd256, 1'b0);
    wait_idle("s6_idle", 1000);
    inj_resp_at = -1;
    chk("s6_err", err, 1);
    chk("s6_words", word_idx, 32);
    start_frame(32'h4200, 32'd128, 1'b0);
    wait_idle("s6b_idle", 1000);
    chk("s6_err_sticky", err, 1);
    chk("s6b_words", word_idx, 16);

    // reset in the middle of a burst
    dout_ready = 1'b0;
    start_frame(32'h5000, 32'd512, 1'b0);
    n = 0;
    while (level < 10'd8 && n < 200) begin step(); n++; end
    rst_n = 1'b0;
    #1;
    chk("mr_arvalid", axi.arvalid, 0);
    chk("mr_rready", axi.rready, 0);
    chk("mr_cfg_ready", cfg_ready, 0);
    chk("mr_busy", busy, 0);
    chk("mr_err", err, 0);
    chk("mr_level", level, 0);
    chk("mr_dout_valid", dout_valid, 0);
    chk("mr_araddr", axi.araddr, 0);
    chk("mr_frame_done", frame_done, 0);
    repeat (2) step();
    rst_n = 1'b1;
    dout_ready = 1'b1;
    step();
    chk("mr_cfg_ready_rel", cfg_ready, 1);
    chk("mr_level_rel", level, 0);
    stray = 1;
    repeat (3) step();
    chk("late_beat_err", err, 1);

    // early rlast on beat 15 of the first burst
    do_reset();
    skip_at = 15;
    inj_early = 1;
    start_frame(32'h6000, 32'd256, 1'b0);
    wait_idle("s7_idle", 1000);
    chk("s7_err", err, 1);
    chk("s7_words", word_idx, 31);
    skip_at = 1 << 30;

    // illegal length: no AR, error flagged, stays idle
    do_reset();
    start_frame(32'h7000, 32'd100, 1'b0);
    repeat (10) step();
    chk("s8_err", err, 1);
    chk("s8_busy", busy, 0);
    chk("s8_ar_count", ar_log.size(), 0);
    chk("s8_cfg_ready", cfg_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
